// File: rtl/uart_tx_buffered_if.sv
// Write-side and status bundle of the buffered UART transmitter.
interface uart_tx_buffered_if #(
  parameter int FIFO_DEPTH = 16
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic             wr_en;
  logic [7:0]       wr_data;
  logic             full;
  logic             empty;
  logic [LVL_W-1:0] level;
  logic             overflow;
  logic             busy;
  logic             tx_pin;

  modport master (
    output wr_en, wr_data,
    input  full, empty, level, overflow, busy, tx_pin
  );

  modport slave (
    input  wr_en, wr_data,
    output full, empty, level, overflow, busy, tx_pin
  );
endinterface

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: byte FIFO feeding a start/data/parity/stop serialiser.
module uart_tx_buffered #(
  parameter int CLOCK      = 12000000,
  parameter int BAUDRATE   = 9600,
  parameter int FIFO_DEPTH = 16,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic              clk,
  input  logic              rst,
  uart_tx_buffered_if.slave bus
);
  localparam int BIT_TICKS = CLOCK / BAUDRATE;
  localparam int CNT_W     = $clog2(BIT_TICKS);
  localparam int PTR_W     = $clog2(FIFO_DEPTH);
  localparam int LVL_W     = PTR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [LVL_W-1:0] count_q;
  logic [LVL_W-1:0] count_d;
  logic             overflow_q;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       idx_q;
  logic [7:0]       shift_q;
  logic             par_q;
  logic             tx_q;

  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             bit_end;
  logic             frame_end;
  logic [7:0]       head;
  logic             head_par;

  assign full      = (count_q == LVL_W'(FIFO_DEPTH));
  assign empty     = (count_q == '0);
  assign push      = bus.wr_en && !full;
  assign bit_end   = (cnt_q == CNT_W'(BIT_TICKS - 1));
  assign frame_end = (state_q == S_STOP) && bit_end &&
                     ((STOP_BITS == 1) || (idx_q == 3'd1));
  // Pop only from a non-empty FIFO, so a byte written this cycle cannot leave this cycle.
  assign pop       = !empty && ((state_q == S_IDLE) || frame_end);
  assign head      = mem_q[rd_ptr_q];
  assign head_par  = (PARITY == 2) ? ~^head : ^head;

  assign bus.full     = full;
  assign bus.empty    = empty;
  assign bus.level    = count_q;
  assign bus.overflow = overflow_q;
  assign bus.busy     = (state_q != S_IDLE);
  assign bus.tx_pin   = tx_q;

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + LVL_W'(1);
    end else if (!push && pop) begin
      count_d = count_q - LVL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
      if (bus.wr_en && full) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.wr_data;
  end

  // tx_q follows the current state's line level, so the line trails the state by one clock.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      cnt_q <= bit_end ? '0 : cnt_q + CNT_W'(1);
      unique case (state_q)
        S_IDLE: begin
          tx_q  <= 1'b1;
          cnt_q <= '0;
          if (pop) begin
            shift_q <= head;
            par_q   <= head_par;
            idx_q   <= '0;
            state_q <= S_START;
          end
        end
        S_START: begin
          tx_q <= 1'b0;
          if (bit_end) state_q <= S_DATA;
        end
        S_DATA: begin
          tx_q <= shift_q[0];
          if (bit_end) begin
            shift_q <= shift_q >> 1;
            if (idx_q == 3'd7) begin
              idx_q   <= '0;
              state_q <= (PARITY != 0) ? S_PARITY : S_STOP;
            end else begin
              idx_q <= idx_q + 3'd1;
            end
          end
        end
        S_PARITY: begin
          tx_q <= par_q;
          if (bit_end) state_q <= S_STOP;
        end
        S_STOP: begin
          tx_q <= 1'b1;
          if (frame_end) begin
            if (pop) begin
              shift_q <= head;
              par_q   <= head_par;
              idx_q   <= '0;
              state_q <= S_START;
            end else begin
              state_q <= S_IDLE;
            end
          end else if (bit_end) begin
            idx_q <= idx_q + 3'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/uart_tx_buffered.md
Name: uart_tx_buffered

Overview:
- Buffered UART transmitter: the transmit end for the existing UART receiver.
- Accepts bytes through a write strobe into an internal FIFO and serialises them on tx_pin as 8N1 frames by default; parity and stop-bit count are configurable.
- Sits between core logic (e.g. a memory dump or debug stream) and the board TX pin. Frames are sent back-to-back with no idle gap while the FIFO is non-empty.

Parameters:
- CLOCK, 12000000, system clock frequency in Hz.
- BAUDRATE, 9600, line rate in baud; BIT_TICKS = CLOCK/BAUDRATE (integer division), must be >= 2.
- FIFO_DEPTH, 16, FIFO entries; power of two, >= 2. All entries are usable (count-based full flag).
- PARITY, 0, parity mode: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1, stop bit count: 1 or 2.

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst  input  1  synchronous reset, active-high.
- wr_en  input  1  write strobe; one byte per asserted cycle.
- wr_data  input  8  byte to enqueue, sampled when wr_en=1.
- full  output  1  FIFO holds FIFO_DEPTH entries.
- empty  output  1  FIFO holds 0 entries.
- level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- overflow  output  1  sticky; set when a write hits a full FIFO, cleared only by rst.
- busy  output  1  high while a frame is on the line, i.e. FSM not in IDLE.
- tx_pin  output  1  serial output, registered, idle high.

Behaviour:
- Reset (rst=1 at posedge): FIFO pointers and level = 0, so empty=1, full=0. overflow=0, busy=0, tx_pin=1, FSM=IDLE, baud counter=0. FIFO contents are don't-care. Reset mid-frame aborts the frame; tx_pin is high from the first cycle after reset.
- FIFO: full/empty/level are combinational from the registered count.
  - Write accepted iff wr_en && !full, evaluated on the pre-edge state.
  - A write while full is dropped and sets overflow, even if a pop occurs the same cycle.
  - Simultaneous accepted write and pop leaves level unchanged.
  - A write into an empty FIFO cannot be popped in the same cycle.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: if !empty, pop the head into an 8-bit shift register, compute the parity bit, clear baud counter and bit index, go to START.
  - START: tx_pin=0 for BIT_TICKS clocks.
  - DATA: 8 bits LSB first, BIT_TICKS clocks each.
  - PARITY: present only if PARITY!=0. Bit value: even mode gives ^data; odd mode gives ~^data.
  - STOP: tx_pin=1 for STOP_BITS*BIT_TICKS clocks. At the end, if !empty, pop and go directly to START (no idle cycle); else go to IDLE.
- Baud counter: counts 0..BIT_TICKS-1 and is restarted at each frame start, so every bit lasts exactly BIT_TICKS clocks. The bit advances when the counter = BIT_TICKS-1.
- Latency: wr_en at edge N into an idle, empty block → pop at edge N+1 → tx_pin falls after edge N+2.
- tx_pin is driven from a flop. busy=1 from the pop edge until the last stop bit ends.
- Frame length: (1 + 8 + (PARITY!=0) + STOP_BITS) * BIT_TICKS clocks.

Test Plan (CLOCK=16, BAUDRATE=1, so BIT_TICKS=16; FIFO_DEPTH=4 unless noted):
- Reset then idle 100 cycles → tx_pin=1, busy=0, empty=1, level=0, overflow=0.
- Write 0xA5 once → tx_pin low 2 cycles after the write for 16 clocks, then bits 1,0,1,0,0,1,0,1 (16 clocks each), then high 16 clocks. busy drops after 160 clocks; empty=1.
- Write 0x01,0x02,0x03 on consecutive cycles → level peaks at 2 (the first byte pops immediately). Three frames are sent back-to-back with a start bit immediately after each stop bit; total 480 clocks from the first start bit.
- Write 6 bytes on consecutive cycles while idle → 5 accepted (1 popped + 4 stored), 6th dropped. overflow=1 and stays 1 after all frames complete; the received sequence equals the first 5 bytes.
- PARITY=1 with 0x07 → parity bit 1, frame 176 clocks. PARITY=2 with 0x07 → parity bit 0. STOP_BITS=2 with PARITY=0 → stop high 32 clocks, next start follows immediately.
- Assert rst for 1 cycle at the 5th data bit of a frame with 2 bytes queued → tx_pin=1 and busy=0 the next cycle, level=0, no further start bit without a new write.
